// File: rtl/mem_io_pkg.sv
// ============================================================================
// Module : mem_io_pkg
// Brief  : Address map constants and I/O decode helper for mem_io_responder.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mem_io_pkg;

  localparam logic [1:0]  IO_SEL       = 2'b11;
  localparam logic [17:0] IO_UART_ADDR = 18'h30000;
  localparam logic [17:0] IO_CTRL_ADDR = 18'h30004;

  function automatic logic is_io(input logic [17:0] a);
    return (a[17:16] == IO_SEL);
  endfunction

endpackage

`default_nettype wire

// File: rtl/byte_fifo.sv
// ============================================================================
// Module : byte_fifo
// Brief  : Byte FIFO with occupancy count; a push while full is accepted
//          only when a pop happens in the same cycle.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module byte_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_push,
  input  logic [7:0]                 i_din,
  input  logic                       i_pop,
  output logic [7:0]                 o_dout,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] C_DEPTH = (PTR_W+1)'(DEPTH);

  logic [7:0]       r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_wr;
  logic             w_rd;

  assign o_full  = (r_count == C_DEPTH);
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_dout  = r_mem[r_rd_ptr];

  assign w_rd = i_pop && !o_empty;
  assign w_wr = i_push && (!o_full || w_rd);

  // Storage is deliberately not reset; only pointers and count are.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_io_responder.sv
// ============================================================================
// Module : mem_io_responder
// Brief  : Byte-serial memory bus responder: RAM plus UART TX FIFO, RX holding
//          register and halt register mapped at 0x30000.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_io_responder
  import mem_io_pkg::*;
#(
  parameter int    RAM_ADDR_W    = 17,
  parameter int    TX_FIFO_DEPTH = 8,
  parameter string INIT_FILE     = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic [31:0] mem_a,
  input  logic        mem_wr,
  input  logic [7:0]  mem_dout,
  output logic [7:0]  mem_din,
  output logic        io_buffer_full,
  output logic        uart_tx_valid,
  output logic [7:0]  uart_tx_data,
  input  logic        uart_tx_ready,
  input  logic        uart_rx_valid,
  input  logic [7:0]  uart_rx_data,
  output logic        tx_overflow,
  output logic        sim_halt
);

  localparam int CNT_W = $clog2(TX_FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] C_FULL_MARK = CNT_W'(TX_FIFO_DEPTH - 1);

  logic [7:0]            r_ram [2**RAM_ADDR_W];
  logic [7:0]            r_mem_din;
  logic [7:0]            r_rx_data;
  logic                  r_rx_valid;
  logic                  r_tx_overflow;
  logic                  r_sim_halt;

  logic [17:0]           w_addr;
  logic                  w_io;
  logic                  w_uart_sel;
  logic                  w_ctrl_sel;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_rx_clear;
  logic                  w_fifo_full;
  logic                  w_fifo_empty;
  logic [CNT_W-1:0]      w_fifo_count;
  logic [7:0]            w_read_data;
  logic                  w_unused_addr;

  assign w_addr        = mem_a[17:0];
  assign w_unused_addr = ^mem_a[31:18];
  assign w_io          = is_io(w_addr);
  assign w_uart_sel    = (w_addr == IO_UART_ADDR);
  assign w_ctrl_sel    = (w_addr == IO_CTRL_ADDR);

  assign w_push     = rdy && mem_wr && w_uart_sel;
  assign w_pop      = uart_tx_valid && uart_tx_ready;
  assign w_rx_clear = rdy && !mem_wr && w_uart_sel;

  always_ff @(posedge clk) begin
    if (rdy && mem_wr && !w_io) r_ram[mem_a[RAM_ADDR_W-1:0]] <= mem_dout;
  end

  always_comb begin
    w_read_data = 8'h00;
    if (!w_io)           w_read_data = r_ram[mem_a[RAM_ADDR_W-1:0]];
    else if (w_uart_sel) w_read_data = r_rx_valid ? r_rx_data : 8'h00;
    else if (w_ctrl_sel) w_read_data = {7'b0, r_rx_valid};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mem_din     <= 8'h00;
      r_rx_data     <= 8'h00;
      r_rx_valid    <= 1'b0;
      r_tx_overflow <= 1'b0;
      r_sim_halt    <= 1'b0;
    end else begin
      if (rdy && !mem_wr) r_mem_din <= w_read_data;
      // A new RX byte wins over a clearing read in the same cycle.
      if (uart_rx_valid) begin
        r_rx_data  <= uart_rx_data;
        r_rx_valid <= 1'b1;
      end else if (w_rx_clear) begin
        r_rx_valid <= 1'b0;
      end
      if (w_push && w_fifo_full && !w_pop) r_tx_overflow <= 1'b1;
      if (rdy && mem_wr && w_ctrl_sel)    r_sim_halt    <= 1'b1;
    end
  end

  byte_fifo #(
    .DEPTH (TX_FIFO_DEPTH)
  ) u_tx_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .i_push  (w_push),
    .i_din   (mem_dout),
    .i_pop   (w_pop),
    .o_dout  (uart_tx_data),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  assign mem_din        = r_mem_din;
  assign uart_tx_valid  = !w_fifo_empty;
  assign io_buffer_full = (w_fifo_count >= C_FULL_MARK);
  assign tx_overflow    = r_tx_overflow;
  assign sim_halt       = r_sim_halt;

endmodule

`default_nettype wire

// File: tb/tb_mem_io_responder.sv
// ============================================================================
// Module : tb_mem_io_responder
// Brief  : Directed self-checking bench for mem_io_responder.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_io_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rdy = 1'b1;
  logic [31:0] mem_a = 32'h0;
  logic        mem_wr = 1'b0;
  logic [7:0]  mem_dout = 8'h0;
  logic [7:0]  mem_din;
  logic        io_buffer_full;
  logic        uart_tx_valid;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_ready = 1'b0;
  logic        uart_rx_valid = 1'b0;
  logic [7:0]  uart_rx_data = 8'h0;
  logic        tx_overflow;
  logic        sim_halt;

  int vectors = 0;
  int miscompares = 0;

  localparam logic [31:0] A_UART = 32'h30000;
  localparam logic [31:0] A_CTRL = 32'h30004;

  always #5 clk = ~clk;

  mem_io_responder dut (
    .clk            (clk),
    .rst            (rst),
    .rdy            (rdy),
    .mem_a          (mem_a),
    .mem_wr         (mem_wr),
    .mem_dout       (mem_dout),
    .mem_din        (mem_din),
    .io_buffer_full (io_buffer_full),
    .uart_tx_valid  (uart_tx_valid),
    .uart_tx_data   (uart_tx_data),
    .uart_tx_ready  (uart_tx_ready),
    .uart_rx_valid  (uart_rx_valid),
    .uart_rx_data   (uart_rx_data),
    .tx_overflow    (tx_overflow),
    .sim_halt       (sim_halt)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic bus(input logic wr, input logic [31:0] a, input logic [7:0] d);
    mem_wr = wr; mem_a = a; mem_dout = d;
    cyc();
  endtask

  task automatic park();
    mem_wr = 1'b0; mem_a = 32'h0; mem_dout = 8'h0;
  endtask

  task automatic do_reset();
    park();
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    cyc();
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if ({mem_din, io_buffer_full, uart_tx_valid, tx_overflow, sim_halt} !== 12'h000) begin
      miscompares++;
      $display("FAIL reset_state: got din=%h full=%b valid=%b ovf=%b halt=%b, want all zero",
               mem_din, io_buffer_full, uart_tx_valid, tx_overflow, sim_halt);
    end
  endtask

  task automatic test_ram();
    logic [7:0] exp [4] = '{8'h78, 8'h56, 8'h34, 8'h12};
    for (int i = 0; i < 4; i++) bus(1'b1, 32'h100 + i, exp[i]);
    vectors++;
    if (mem_din !== 8'h00) begin
      miscompares++;
      $display("FAIL ram_write_keeps_din: got %h want 00", mem_din);
    end
    for (int i = 0; i < 4; i++) begin
      bus(1'b0, 32'h100 + i, 8'h0);
      vectors++;
      if (mem_din !== exp[i]) begin
        miscompares++;
        $display("FAIL ram_read[%0d]: got %h want %h", i, mem_din, exp[i]);
      end
    end
    park();
  endtask

  task automatic test_tx_fill();
    uart_tx_ready = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      bus(1'b1, A_UART, 8'h41);
      if (i == 6 || i == 7) begin
        vectors++;
        if (io_buffer_full !== (i == 7)) begin
          miscompares++;
          $display("FAIL tx_fill_full_after_%0d: got %b want %b", i, io_buffer_full, (i == 7));
        end
      end
      if (i == 8 || i == 9) begin
        vectors++;
        if (tx_overflow !== (i == 9)) begin
          miscompares++;
          $display("FAIL tx_overflow_after_%0d: got %b want %b", i, tx_overflow, (i == 9));
        end
      end
    end
    park();
    vectors++;
    if (uart_tx_valid !== 1'b1 || uart_tx_data !== 8'h41) begin
      miscompares++;
      $display("FAIL tx_fill_head: got valid=%b data=%h want 1/41", uart_tx_valid, uart_tx_data);
    end
    do_reset();
  endtask

  task automatic test_drain();
    logic [7:0] exp [3] = '{8'h41, 8'h42, 8'h43};
    uart_tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) bus(1'b1, A_UART, exp[i]);
    park();
    uart_tx_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++;
      if (uart_tx_valid !== 1'b1 || uart_tx_data !== exp[i]) begin
        miscompares++;
        $display("FAIL drain[%0d]: got valid=%b data=%h want 1/%h", i, uart_tx_valid, uart_tx_data, exp[i]);
      end
      cyc();
    end
    vectors++;
    if (uart_tx_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL drain_empty: got valid=%b want 0", uart_tx_valid);
    end
    uart_tx_ready = 1'b0;
  endtask

  task automatic test_full_push_pop();
    logic [7:0] exp;
    do_reset();
    uart_tx_ready = 1'b0;
    for (int i = 0; i < 8; i++) bus(1'b1, A_UART, 8'h10 + 8'(i));
    uart_tx_ready = 1'b1;
    bus(1'b1, A_UART, 8'h99);
    uart_tx_ready = 1'b0;
    park();
    vectors++;
    if (io_buffer_full !== 1'b1 || tx_overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL full_push_pop_flags: got full=%b ovf=%b want 1/0", io_buffer_full, tx_overflow);
    end
    uart_tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      exp = (i == 7) ? 8'h99 : 8'h11 + 8'(i);
      vectors++;
      if (uart_tx_valid !== 1'b1 || uart_tx_data !== exp) begin
        miscompares++;
        $display("FAIL full_push_pop_drain[%0d]: got valid=%b data=%h want 1/%h", i, uart_tx_valid, uart_tx_data, exp);
      end
      cyc();
    end
    vectors++;
    if (uart_tx_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL full_push_pop_empty: got valid=%b want 0", uart_tx_valid);
    end
    uart_tx_ready = 1'b0;
  endtask

  task automatic test_rx();
    logic [31:0] addrs [7] = '{A_CTRL, A_UART, A_CTRL, A_UART, A_CTRL, A_UART, 32'h30008};
    logic [7:0]  exp   [7] = '{8'h01, 8'h5A, 8'h00, 8'h11, 8'h01, 8'h22, 8'h00};
    uart_rx_valid = 1'b1; uart_rx_data = 8'h5A;
    cyc();
    uart_rx_valid = 1'b0;
    for (int i = 0; i < 7; i++) begin
      if (i == 3) begin
        uart_rx_valid = 1'b1; uart_rx_data = 8'h11;
        cyc();
        uart_rx_valid = 1'b1; uart_rx_data = 8'h22;
      end
      bus(1'b0, addrs[i], 8'h0);
      uart_rx_valid = 1'b0;
      vectors++;
      if (mem_din !== exp[i]) begin
        miscompares++;
        $display("FAIL rx_read[%0d] addr=%h: got %h want %h", i, addrs[i], mem_din, exp[i]);
      end
    end
    park();
  endtask

  task automatic test_rdy();
    bus(1'b1, 32'h10, 8'hAA);
    rdy = 1'b0;
    bus(1'b1, 32'h10, 8'h55);
    bus(1'b1, A_UART, 8'h77);
    rdy = 1'b1;
    vectors++;
    if (uart_tx_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rdy0_no_push: got valid=%b want 0", uart_tx_valid);
    end
    bus(1'b0, 32'h10, 8'h0);
    vectors++;
    if (mem_din !== 8'hAA) begin
      miscompares++;
      $display("FAIL rdy0_ram_write: got %h want aa", mem_din);
    end
    rdy = 1'b0;
    bus(1'b0, 32'h100, 8'h0);
    rdy = 1'b1;
    vectors++;
    if (mem_din !== 8'hAA) begin
      miscompares++;
      $display("FAIL rdy0_din_hold: got %h want aa", mem_din);
    end
    park();
  endtask

  task automatic test_reset_mid_and_halt();
    uart_tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) bus(1'b1, A_UART, 8'h60 + 8'(i));
    park();
    vectors++;
    if (uart_tx_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_reset_pre: got valid=%b want 1", uart_tx_valid);
    end
    #2 rst = 1'b0;
    #1;
    vectors++;
    if (uart_tx_valid !== 1'b0 || mem_din !== 8'h00) begin
      miscompares++;
      $display("FAIL mid_reset_async: got valid=%b din=%h want 0/00", uart_tx_valid, mem_din);
    end
    cyc();
    rst = 1'b1;
    cyc();
    vectors++;
    if (sim_halt !== 1'b0) begin
      miscompares++;
      $display("FAIL halt_pre: got %b want 0", sim_halt);
    end
    bus(1'b1, A_CTRL, 8'h00);
    park();
    vectors++;
    if (sim_halt !== 1'b1) begin
      miscompares++;
      $display("FAIL halt_set: got %b want 1", sim_halt);
    end
  endtask

  initial begin
    test_reset();
    test_ram();
    test_tx_fill();
    test_drain();
    test_full_push_pop();
    test_rx();
    test_rdy();
    test_reset_mid_and_halt();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
